bd_tag_merge_arbiter: RTL and testbench

BD_TAG_MERGE_ARBITER -- requirements
Module: bd_tag_merge_arbiter

---
 rtl/bd_tag_merge_arbiter_pkg.sv | 21 ++
 rtl/bd_tag_merge_arbiter_out_reg.sv | 39 +++
 rtl/bd_tag_merge_arbiter.sv | 106 ++++++++++
 tb/tb_bd_tag_merge_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bd_tag_merge_arbiter_pkg.sv
// Shared definitions for the BD/tag merge arbiter.
//   owner_t        : which requester currently holds the grant
//   LEAF_TAG_COUNT : leaf code carried by tag/count words (low LEAF_W bits)
//   DEFAULT_NDATA  : default merged word width (payload plus leaf code)
package bd_tag_merge_arbiter_pkg;

  localparam int DEFAULT_NDATA = 26;
  localparam int LEAF_W = 5;
  localparam logic [LEAF_W-1:0] LEAF_TAG_COUNT = 5'd30;

  typedef enum logic {
    OWN0 = 1'b0,
    OWN1 = 1'b1
  } owner_t;

  // True when a leaf field marks a tag/count word rather than a BD word.
  function automatic logic is_tag_count(input logic [LEAF_W-1:0] leaf);
    return leaf == LEAF_TAG_COUNT;
  endfunction

endpackage

// File: rtl/bd_tag_merge_arbiter_out_reg.sv
// ChannelOutReg: one-entry valid/data/ack output register.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_v, in_d, in_a  : upstream channel (in_a = loadable & in_v)
//   loadable          : register can take a word this cycle
//   out_v, out_d, out_a : downstream channel, driven straight from flops
module ChannelOutReg
  import bd_tag_merge_arbiter_pkg::*;
#(
  parameter int W = DEFAULT_NDATA
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v,
  input  logic [W-1:0] in_d,
  output logic         in_a,
  output logic         loadable,
  output logic         out_v,
  output logic [W-1:0] out_d,
  input  logic         out_a
);

  // Empty, or the held word leaves at this edge: either way a new word fits.
  assign loadable = !out_v || out_a;
  assign in_a     = loadable && in_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_v <= 1'b0;
      out_d <= '0;
    end else if (in_a) begin
      out_v <= 1'b1;
      out_d <= in_d;
    end else if (out_a) begin
      out_v <= 1'b0;
    end
  end

endmodule

// File: rtl/bd_tag_merge_arbiter.sv
// bd_tag_merge_arbiter: merges a BD word channel (in0) and a tag/count word
// channel (in1) into one output channel, granting one requester at a time
// with a configurable burst limit.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   burst_limit             : max consecutive grants to one requester (0 acts as 1)
//   in0_v / in0_d / in0_a   : BD word channel
//   in1_v / in1_d / in1_a   : tag/count word channel
//   out_v / out_d / out_a   : merged output channel (registered)
//   grant_owner             : current owner, for debug
module bd_tag_merge_arbiter
  import bd_tag_merge_arbiter_pkg::*;
#(
  parameter int NData  = DEFAULT_NDATA,
  parameter int NBurst = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NBurst-1:0] burst_limit,
  input  logic              in0_v,
  input  logic [NData-1:0]  in0_d,
  output logic              in0_a,
  input  logic              in1_v,
  input  logic [NData-1:0]  in1_d,
  output logic              in1_a,
  output logic              out_v,
  output logic [NData-1:0]  out_d,
  input  logic              out_a,
  output logic              grant_owner
);

  owner_t            owner;
  owner_t            owner_next;
  logic [NBurst-1:0] count;
  logic [NBurst-1:0] count_next;
  logic [NBurst-1:0] count_inc;
  logic [NBurst-1:0] limit_eff;
  logic              own_v;
  logic              other_v;
  logic              hit;
  logic              loadable;
  logic              grant_v;
  logic              grant_a;
  logic [NData-1:0]  grant_d;

  assign limit_eff = (burst_limit == '0) ? NBurst'(1) : burst_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= OWN0;
      count <= '0;
    end else begin
      owner <= owner_next;
      count <= count_next;
    end
  end

  // The counter saturates at the limit rather than wrapping, and a limit
  // lowered below the current count is treated as already reached (>=).
  // A requester that is idle while the other is waiting loses the grant
  // even during output back-pressure, so the switch costs one idle cycle.
  always_comb begin
    own_v     = (owner == OWN0) ? in0_v : in1_v;
    other_v   = (owner == OWN0) ? in1_v : in0_v;
    count_inc = count;
    if (grant_a && (count < limit_eff)) begin
      count_inc = count + 1'b1;
    end
    hit        = count_inc >= limit_eff;
    owner_next = owner;
    count_next = count_inc;
    if (other_v && (hit || !own_v)) begin
      owner_next = (owner == OWN0) ? OWN1 : OWN0;
      count_next = '0;
    end
  end

  // Acks are gated by reset so no upstream word is consumed while the
  // output register is being cleared.
  always_comb begin
    in0_a       = 1'b0;
    in1_a       = 1'b0;
    if (!reset && loadable) begin
      in0_a = (owner == OWN0) && in0_v;
      in1_a = (owner == OWN1) && in1_v;
    end
    grant_v     = in0_a || in1_a;
    grant_d     = in1_a ? in1_d : in0_d;
    grant_owner = (owner == OWN1);
  end

  ChannelOutReg #(
    .W(NData)
  ) u_out_reg (
    .clk      (clk),
    .reset    (reset),
    .in_v     (grant_v),
    .in_d     (grant_d),
    .in_a     (grant_a),
    .loadable (loadable),
    .out_v    (out_v),
    .out_d    (out_d),
    .out_a    (out_a)
  );

endmodule

// File: tb/tb_bd_tag_merge_arbiter.sv
// Testbench for bd_tag_merge_arbiter: table-driven arbitration patterns,
// hand-written back-pressure / reset / limit-change sequences and a random
// phase, all feeding a per-source scoreboard of expected words.
module tb_bd_tag_merge_arbiter;
  import bd_tag_merge_arbiter_pkg::*;

  localparam int NData  = DEFAULT_NDATA;
  localparam int NBurst = 4;

  logic              clk;
  logic              reset;
  logic [NBurst-1:0] burst_limit;
  logic              in0_v, in0_a, in1_v, in1_a;
  logic [NData-1:0]  in0_d, in1_d, out_d;
  logic              out_v, out_a, grant_owner;

  bd_tag_merge_arbiter #(
    .NData (NData),
    .NBurst(NBurst)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .burst_limit (burst_limit),
    .in0_v       (in0_v),
    .in0_d       (in0_d),
    .in0_a       (in0_a),
    .in1_v       (in1_v),
    .in1_d       (in1_d),
    .in1_a       (in1_a),
    .out_v       (out_v),
    .out_d       (out_d),
    .out_a       (out_a),
    .grant_owner (grant_owner)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [NBurst-1:0] limit;
    bit                v0;
    bit                v1;
    int                words;
    logic [31:0]       exp_src;
    int                exp_first;
    bit                check_owner;
    bit                exp_owner;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int errors = 0;
  logic [NData-1:0] exp0[$];
  logic [NData-1:0] exp1[$];
  bit out_src[$];
  int out_t[$];
  int seq0 = 0;
  int seq1 = 0;
  int sample_idx = 0;

  logic             s_out_v, s_in0_a, s_in1_a, s_owner;
  logic [NData-1:0] s_out_d;
  logic [NData-1:0] held;

  function automatic logic [NData-1:0] word0(input int s);
    logic [31:0] sv;
    sv = s;
    return {sv[NData-LEAF_W-1:0], 5'd3};
  endfunction

  function automatic logic [NData-1:0] word1(input int s);
    logic [31:0] sv;
    sv = s;
    return {sv[NData-LEAF_W-1:0], LEAF_TAG_COUNT};
  endfunction

  function automatic logic [31:0] src_pattern(input int n);
    logic [31:0] p;
    p = '0;
    for (int j = 0; j < n; j++) p[j] = out_src[j];
    return p;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit v0, input bit v1, input bit oa);
    in0_v = v0;
    in1_v = v1;
    out_a = oa;
  endtask

  // Sample at the falling edge, score the transfers that the next rising
  // edge will perform, then advance the senders once that edge has passed.
  task automatic run_cycle();
    bit acc0, acc1;
    @(negedge clk);
    s_out_v = out_v;
    s_out_d = out_d;
    s_in0_a = in0_a;
    s_in1_a = in1_a;
    s_owner = grant_owner;
    checkOutput("ack_exclusive", 32'(s_in0_a & s_in1_a), 32'd0);
    if (s_out_v && out_a) begin
      if (is_tag_count(s_out_d[LEAF_W-1:0])) begin
        out_src.push_back(1'b1);
        if (exp1.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_in1: got 0x%0h, expected no word", s_out_d);
        end else begin
          checkOutput("sb_in1", 32'(s_out_d), 32'(exp1.pop_front()));
        end
      end else begin
        out_src.push_back(1'b0);
        if (exp0.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_in0: got 0x%0h, expected no word", s_out_d);
        end else begin
          checkOutput("sb_in0", 32'(s_out_d), 32'(exp0.pop_front()));
        end
      end
      out_t.push_back(sample_idx);
    end
    acc0 = in0_v && s_in0_a;
    acc1 = in1_v && s_in1_a;
    if (acc0) exp0.push_back(in0_d);
    if (acc1) exp1.push_back(in1_d);
    @(posedge clk);
    #1;
    if (acc0) seq0++;
    if (acc1) seq1++;
    in0_d = word0(seq0);
    in1_d = word1(seq1);
    sample_idx++;
  endtask

  // Reset for two edges with the output stalled, so any registered word is
  // discarded rather than delivered; the scoreboard forgets it as well.
  task automatic do_reset();
    reset = 1'b1;
    out_a = 1'b0;
    run_cycle();
    checkOutput("rst_in0_a", 32'(s_in0_a), 32'd0);
    checkOutput("rst_in1_a", 32'(s_in1_a), 32'd0);
    run_cycle();
    checkOutput("rst_out_v", 32'(s_out_v), 32'd0);
    checkOutput("rst_owner", 32'(s_owner), 32'd0);
    checkOutput("rst_out_d", 32'(s_out_d), 32'd0);
    reset = 1'b0;
    exp0.delete();
    exp1.delete();
    out_src.delete();
    out_t.delete();
    sample_idx = 0;
  endtask

  initial begin
    int budget;
    vecs[0] = '{4'd4,  1'b1, 1'b1, 16, 32'h0000F0F0, 1, 1'b0, 1'b0};
    vecs[1] = '{4'd0,  1'b1, 1'b1, 16, 32'h0000AAAA, 1, 1'b0, 1'b0};
    vecs[2] = '{4'd1,  1'b1, 1'b1, 16, 32'h0000AAAA, 1, 1'b0, 1'b0};
    vecs[3] = '{4'd2,  1'b0, 1'b1, 20, 32'h000FFFFF, 2, 1'b1, 1'b1};
    vecs[4] = '{4'd3,  1'b1, 1'b0, 16, 32'h00000000, 1, 1'b1, 1'b0};
    vecs[5] = '{4'd15, 1'b1, 1'b1, 16, 32'h00008000, 1, 1'b0, 1'b0};
    vecs[6] = '{4'd2,  1'b1, 1'b1, 16, 32'h0000CCCC, 1, 1'b0, 1'b0};

    reset       = 1'b1;
    burst_limit = '0;
    in0_v       = 1'b0;
    in1_v       = 1'b0;
    out_a       = 1'b0;
    in0_d       = word0(0);
    in1_d       = word1(0);

    for (int i = 0; i < 7; i++) begin
      burst_limit = vecs[i].limit;
      in0_v       = vecs[i].v0;
      in1_v       = vecs[i].v1;
      do_reset();
      applyStimulus(vecs[i].v0, vecs[i].v1, 1'b1);
      run_cycle();
      checkOutput($sformatf("vec%0d_first_in0_a", i), 32'(s_in0_a), 32'(vecs[i].v0));
      budget = 0;
      while (out_src.size() < vecs[i].words && budget < 100) begin
        run_cycle();
        budget++;
      end
      checkOutput($sformatf("vec%0d_words", i), out_src.size(), vecs[i].words);
      if (out_src.size() >= vecs[i].words) begin
        checkOutput($sformatf("vec%0d_pattern", i), src_pattern(vecs[i].words), vecs[i].exp_src);
        checkOutput($sformatf("vec%0d_first_t", i), out_t[0], vecs[i].exp_first);
        checkOutput($sformatf("vec%0d_span", i), out_t[vecs[i].words-1] - out_t[0],
                    vecs[i].words - 1);
      end
      if (vecs[i].check_owner) begin
        checkOutput($sformatf("vec%0d_owner", i), 32'(s_owner), 32'(vecs[i].exp_owner));
      end
    end

    // Back-pressure: stall with in0's second word held for five cycles.
    burst_limit = 4'd4;
    in0_v = 1'b1;
    in1_v = 1'b1;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycle();
    run_cycle();
    applyStimulus(1'b1, 1'b1, 1'b0);
    held = word0(seq0 - 1);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      checkOutput("bp_out_v", 32'(s_out_v), 32'd1);
      checkOutput("bp_out_d", 32'(s_out_d), 32'(held));
      checkOutput("bp_in0_a", 32'(s_in0_a), 32'd0);
      checkOutput("bp_in1_a", 32'(s_in1_a), 32'd0);
      checkOutput("bp_owner", 32'(s_owner), 32'd0);
    end
    out_src.delete();
    out_t.delete();
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycle();
    checkOutput("bp_resume_in0_a", 32'(s_in0_a), 32'd1);
    repeat (3) run_cycle();
    checkOutput("bp_words", out_src.size(), 4);
    if (out_src.size() == 4) begin
      checkOutput("bp_pattern", src_pattern(4), 32'b1000);
      checkOutput("bp_first_t", out_t[0], 7);
      checkOutput("bp_last_t", out_t[3], 10);
    end

    // Reset in the middle of an in1 burst, after two of its words.
    burst_limit = 4'd4;
    in0_v = 1'b0;
    in1_v = 1'b1;
    do_reset();
    applyStimulus(1'b0, 1'b1, 1'b1);
    repeat (3) run_cycle();
    checkOutput("mb_pre_words", out_src.size(), 1);
    checkOutput("mb_pre_owner", 32'(s_owner), 32'd1);
    in0_v = 1'b1;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    run_cycle();
    checkOutput("mb_in0_a", 32'(s_in0_a), 32'd1);
    checkOutput("mb_in1_a", 32'(s_in1_a), 32'd0);
    repeat (5) run_cycle();
    checkOutput("mb_words", out_src.size(), 5);
    if (out_src.size() >= 5) begin
      checkOutput("mb_pattern", src_pattern(5), 32'b10000);
    end

    // Lowering the limit below a running count ends the burst at once.
    burst_limit = 4'd8;
    in0_v = 1'b1;
    in1_v = 1'b1;
    do_reset();
    applyStimulus(1'b1, 1'b1, 1'b1);
    repeat (3) run_cycle();
    burst_limit = 4'd2;
    repeat (3) run_cycle();
    checkOutput("lim_words", out_src.size(), 5);
    if (out_src.size() >= 5) begin
      checkOutput("lim_pattern", src_pattern(5), 32'b10000);
    end

    // Random valid / ready traffic with occasional limit changes.
    burst_limit = 4'd3;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) burst_limit = NBurst'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3) != 0);
      run_cycle();
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (3) run_cycle();
    checkOutput("drain_in0", exp0.size(), 0);
    checkOutput("drain_in1", exp1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
